// File: rtl/mem_init_seq.sv
// Memory-fill sequencer: writes ZERO/INDEX/LFSR/CONST patterns into N_CH target memories in turn.
// Optional macro MEM_INIT_SEQ_BYTEMASK_EN: LFSR-mode data keeps only the low LFSR byte.
module mem_init_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int N_CH   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                start,
    input  logic [2*N_CH-1:0]   cfg_mode,
    input  logic [ADDR_W:0]     cfg_len,
    input  logic [15:0]         cfg_seed,
    input  logic [DATA_W-1:0]   cfg_const,
    input  logic                wr_ready,
    output logic                wr_en,
    output logic [2:0]          wr_ch,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                busy,
    output logic                done,
    output logic [1:0]          o_dbg_state,
    output logic [15:0]         o_dbg_lfsr
);

    // Handshake: a write transfers on a rising edge where wr_en and wr_ready are both high;
    // while wr_en=1 and wr_ready=0, wr_ch/wr_addr/wr_data hold their values.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        NEXT_CH = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [2:0]      LAST_CH  = 3'(N_CH - 1);
    localparam logic [15:0]     LFSR_DEF = 16'hACE1;

    state_t              r_state;
    logic [2*N_CH-1:0]   r_mode;
    logic [ADDR_W:0]     r_len;
    logic [DATA_W-1:0]   r_const;
    logic [15:0]         r_lfsr;
    logic                r_wr_en;
    logic [2:0]          r_wr_ch;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_busy;
    logic                r_done;

    logic [ADDR_W:0]     w_len_sat;
    logic [15:0]         w_seed;
    logic [ADDR_W:0]     w_addr_ext;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic                w_last;
    logic [2:0]          w_nxt_ch;
    logic [1:0]          w_cur_mode;
    logic [1:0]          w_nxt_mode;
    logic [15:0]         w_lfsr_adv;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [DATA_W-1:0] lfsr_data(input logic [15:0] s);
`ifdef MEM_INIT_SEQ_BYTEMASK_EN
        return {{(DATA_W-8){1'b0}}, s[7:0]};
`else
        return {(DATA_W/16){s}};
`endif
    endfunction

    function automatic logic [DATA_W-1:0] word_data(input logic [1:0]        mode,
                                                    input logic [ADDR_W-1:0] addr,
                                                    input logic [15:0]       s,
                                                    input logic [DATA_W-1:0] k);
        case (mode)
            2'b00:   return '0;
            2'b01:   return DATA_W'(addr);
            2'b10:   return lfsr_data(s);
            default: return k;
        endcase
    endfunction

    always_comb begin
        w_len_sat  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
        w_seed     = (cfg_seed == 16'h0000) ? LFSR_DEF : cfg_seed;
        // Compare in ADDR_W+1 bits so a full 2^ADDR_W channel ends without wrapping addr.
        w_addr_ext = {1'b0, r_wr_addr} + {{ADDR_W{1'b0}}, 1'b1};
        w_addr_inc = w_addr_ext[ADDR_W-1:0];
        w_last     = (w_addr_ext == r_len);
        w_nxt_ch   = (r_wr_ch == LAST_CH) ? r_wr_ch : r_wr_ch + 3'd1;
        w_cur_mode = r_mode[int'(r_wr_ch)*2 +: 2];
        w_nxt_mode = r_mode[int'(w_nxt_ch)*2 +: 2];
        w_lfsr_adv = (w_cur_mode == 2'b10) ? lfsr_step(r_lfsr) : r_lfsr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mode    <= '0;
            r_len     <= '0;
            r_const   <= '0;
            r_lfsr    <= LFSR_DEF;
            r_wr_en   <= 1'b0;
            r_wr_ch   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (clr) begin
            r_state <= IDLE;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode    <= cfg_mode;
                        r_len     <= w_len_sat;
                        r_const   <= cfg_const;
                        r_lfsr    <= w_seed;
                        r_wr_ch   <= '0;
                        r_wr_addr <= '0;
                        r_wr_data <= word_data(cfg_mode[1:0], '0, w_seed, cfg_const);
                        r_busy    <= 1'b1;
                        if (w_len_sat == '0) begin
                            r_state <= NEXT_CH;
                            r_wr_en <= 1'b0;
                        end else begin
                            r_state <= WRITE;
                            r_wr_en <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        r_lfsr <= w_lfsr_adv;
                        if (w_last) begin
                            r_state <= NEXT_CH;
                            r_wr_en <= 1'b0;
                        end else begin
                            r_wr_addr <= w_addr_inc;
                            r_wr_data <= word_data(w_cur_mode, w_addr_inc, w_lfsr_adv, r_const);
                        end
                    end
                end
                NEXT_CH: begin
                    if (r_wr_ch == LAST_CH) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_wr_ch   <= w_nxt_ch;
                        r_wr_addr <= '0;
                        r_wr_data <= word_data(w_nxt_mode, '0, r_lfsr, r_const);
                        if (r_len == '0) begin
                            r_state <= NEXT_CH;
                        end else begin
                            r_state <= WRITE;
                            r_wr_en <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_ch       = r_wr_ch;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;
    assign o_dbg_lfsr  = r_lfsr;

endmodule

// File: tb/tb_mem_init_seq.sv
// Bench for mem_init_seq: a per-cycle vector table for a mixed-mode fill, then hand-written
// sequences for saturation, empty channels, abort, and reset.
module tb_mem_init_seq;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int N_CH   = 3;

`ifdef MEM_INIT_SEQ_BYTEMASK_EN
  localparam logic [31:0] L_ACE1 = 32'h000000E1;
  localparam logic [31:0] L_E270 = 32'h00000070;
  localparam logic [31:0] L_0001 = 32'h00000001;
  localparam logic [31:0] L_B400 = 32'h00000000;
`else
  localparam logic [31:0] L_ACE1 = 32'hACE1ACE1;
  localparam logic [31:0] L_E270 = 32'hE270E270;
  localparam logic [31:0] L_0001 = 32'h00010001;
  localparam logic [31:0] L_B400 = 32'hB400B400;
`endif

  logic              clk = 1'b0;
  logic              rst, clr, start, wr_ready;
  logic [2*N_CH-1:0] cfg_mode;
  logic [ADDR_W:0]   cfg_len;
  logic [15:0]       cfg_seed;
  logic [DATA_W-1:0] cfg_const;
  logic              wr_en, busy, done;
  logic [2:0]        wr_ch;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        dbg_state;
  logic [15:0]       dbg_lfsr;

  typedef struct packed {
    logic        en;
    logic [2:0]  ch;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    logic start;
    logic ready;
    obs_t exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  mem_init_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start),
    .cfg_mode(cfg_mode), .cfg_len(cfg_len), .cfg_seed(cfg_seed), .cfg_const(cfg_const),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done),
    .o_dbg_state(dbg_state), .o_dbg_lfsr(dbg_lfsr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t mk(logic en, logic [2:0] ch, logic [7:0] addr, logic [31:0] data,
                              logic b, logic d);
    obs_t o;
    o.en = en; o.ch = ch; o.addr = addr; o.data = data; o.busy = b; o.done = d;
    return o;
  endfunction

  task automatic check_obs(string name, obs_t exp);
    obs_t act;
    act = mk(wr_en, wr_ch, wr_addr, wr_data, busy, done);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got en=%0b ch=%0d addr=%0d data=%h busy=%0b done=%0b, want en=%0b ch=%0d addr=%0d data=%h busy=%0b done=%0b",
               name, act.en, act.ch, act.addr, act.data, act.busy, act.done,
               exp.en, exp.ch, exp.addr, exp.data, exp.busy, exp.done);
    end
  endtask

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  vec_t vecs[14];

  initial begin
    int en_cnt, done_cnt, done_at, got;
    logic [DATA_W-1:0] e;

    rst = 1'b1; clr = 1'b0; start = 1'b0; wr_ready = 1'b0;
    cfg_mode = '0; cfg_len = '0; cfg_seed = '0; cfg_const = '0;
    tick();
    tick();
    check_obs("reset_outputs", mk(0, 0, 0, 0, 0, 0));
    check_val("reset_lfsr", 32'(dbg_lfsr), 32'h0000ACE1);
    check_val("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;

    // mixed fill: ch0 INDEX, ch1 CONST, ch2 LFSR, len 2, seed 0 -> 16'hACE1
    vecs[0]  = '{1, 1, mk(1, 0, 0, 32'd0, 1, 0)};
    vecs[1]  = '{0, 1, mk(1, 0, 1, 32'd1, 1, 0)};
    vecs[2]  = '{0, 1, mk(0, 0, 1, 32'd1, 1, 0)};
    vecs[3]  = '{0, 1, mk(1, 1, 0, 32'hDEADBEEF, 1, 0)};
    vecs[4]  = '{0, 0, mk(1, 1, 0, 32'hDEADBEEF, 1, 0)};
    vecs[5]  = '{0, 1, mk(1, 1, 1, 32'hDEADBEEF, 1, 0)};
    vecs[6]  = '{0, 1, mk(0, 1, 1, 32'hDEADBEEF, 1, 0)};
    vecs[7]  = '{0, 1, mk(1, 2, 0, L_ACE1, 1, 0)};
    vecs[8]  = '{0, 1, mk(1, 2, 1, L_E270, 1, 0)};
    vecs[9]  = '{0, 0, mk(1, 2, 1, L_E270, 1, 0)};
    vecs[10] = '{0, 1, mk(0, 2, 1, L_E270, 1, 0)};
    vecs[11] = '{0, 1, mk(0, 2, 1, L_E270, 0, 1)};
    vecs[12] = '{1, 1, mk(0, 2, 1, L_E270, 0, 0)};
    vecs[13] = '{0, 1, mk(0, 2, 1, L_E270, 0, 0)};

    cfg_mode = 6'b10_11_01; cfg_len = 9'd2; cfg_seed = 16'h0000; cfg_const = 32'hDEADBEEF;
    for (int i = 0; i < 14; i++) begin
      if (i == 1) begin
        cfg_mode = 6'b00_00_00; cfg_len = 9'd7; cfg_const = 32'h0;
      end
      start = vecs[i].start;
      wr_ready = vecs[i].ready;
      tick();
      check_obs($sformatf("vec%0d", i), vecs[i].exp);
      if (i == 9) check_val("stall_lfsr_hold", 32'(dbg_lfsr), 32'h0000E270);
    end
    start = 1'b0;

    // cfg_len above 2^ADDR_W saturates: 256 INDEX writes per channel, no wrap
    for (int c = 0; c < N_CH; c++)
      for (int a = 0; a < 256; a++) exp_q.push_back(DATA_W'(a));
    cfg_mode = 6'b01_01_01; cfg_len = 9'h1FF; wr_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 2000 && done_cnt == 0; c++) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sat_extra_write: got addr %0d, want no write", wr_addr);
        end else begin
          e = exp_q.pop_front();
          check_val("sat_data", wr_data, e);
          check_val("sat_addr", 32'(wr_addr), e);
        end
      end
      if (done) done_cnt++;
      else tick();
    end
    check_val("sat_done_seen", done_cnt, 1);
    check_val("sat_queue_empty", exp_q.size(), 0);
    tick();

    // len 0 on every channel: no writes, one done after three NEXT_CH cycles
    cfg_len = 9'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check_obs("zero_first", mk(0, 0, 0, 32'd0, 1, 0));
    en_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      if (wr_en) en_cnt++;
      if (done) begin done_cnt++; done_at = c; end
      tick();
    end
    check_val("zero_wr_en_count", en_cnt, 0);
    check_val("zero_done_count", done_cnt, 1);
    check_val("zero_done_cycle", done_at, 4);

    // clr during the second write of channel 1
    cfg_mode = 6'b01_01_01; cfg_len = 9'd3; start = 1'b1;
    tick();
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      if (wr_en && wr_ch == 3'd1 && wr_addr == 8'd1) got = 1;
      else tick();
    end
    check_val("clr_reach_ch1_a1", got, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_obs("clr_next", mk(0, 1, 1, 32'd1, 0, 0));
    check_val("clr_state", 32'(dbg_state), 32'd0);
    en_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (wr_en) en_cnt++;
      if (done) done_cnt++;
    end
    check_val("clr_quiet", en_cnt + done_cnt, 0);
    clr = 1'b1; start = 1'b1;
    tick();
    check_obs("clr_beats_start", mk(0, 1, 1, 32'd1, 0, 0));
    clr = 1'b0;
    tick();
    start = 1'b0;
    check_obs("restart_ch0", mk(1, 0, 0, 32'd0, 1, 0));

    // LFSR sequence with seed 1, then rst together with clr mid-sequence
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg_mode = 6'b10_10_10; cfg_seed = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    check_obs("seed1_w0", mk(1, 0, 0, L_0001, 1, 0));
    tick();
    check_obs("seed1_w1", mk(1, 0, 1, L_B400, 1, 0));
    check_val("seed1_lfsr", 32'(dbg_lfsr), 32'h0000B400);
    rst = 1'b1; clr = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; clr = 1'b0; start = 1'b0;
    check_obs("rst_clr_outputs", mk(0, 0, 0, 32'd0, 0, 0));
    check_val("rst_clr_lfsr", 32'(dbg_lfsr), 32'h0000ACE1);
    check_val("rst_clr_state", 32'(dbg_state), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done || wr_en) done_cnt++;
    end
    check_val("rst_no_done", done_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
